// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the instruction fetch stage
package core_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] raw;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } fetch_state_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small circular FIFO of fetch entries with synchronous clear
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clear,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A push into a full FIFO is accepted when the head leaves on the same edge.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, in-order imem requests, output buffer and redirect flush
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_raw,
  output logic [31:0] instr_pc
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

  fetch_state_t   state;
  fetch_state_t   state_nxt;
  logic [31:0]    pc;
  logic [OCW-1:0] drop_cnt;
  logic [OCW-1:0] drop_nxt;
  logic [OCW-1:0] outstanding;
  logic [FCW-1:0] fifo_count;
  fetch_entry_t   fifo_head;
  fetch_entry_t   pcq_head;
  fetch_entry_t   req_entry;
  fetch_entry_t   rsp_entry;
  logic           req_fire;
  logic           fifo_push;
  logic           fifo_pop;

  // Outstanding already includes words still owed to an earlier flush,
  // so a redirect simply marks everything left in flight as stale.
  always_comb begin
    drop_nxt = drop_cnt;
    if (redirect_valid)
      drop_nxt = outstanding - OCW'(imem_rsp_valid);
    else if (imem_rsp_valid && (drop_cnt != '0))
      drop_nxt = drop_cnt - OCW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = RUN;
      RUN:     if (redirect_valid && (drop_nxt != '0)) state_nxt = FLUSH;
      FLUSH:   if (drop_nxt == '0) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid = (state == RUN) && !redirect_valid
                     && (int'(fifo_count) + int'(outstanding) < FIFO_DEPTH)
                     && (int'(outstanding) < MAX_OUTSTANDING);
    req_fire       = imem_req_valid && imem_req_ready;
    fifo_push      = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    fifo_pop       = instr_valid && instr_ready;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_nxt;
      if (redirect_valid) pc <= align_pc(redirect_pc);
      else if (req_fire)  pc <= pc + 32'd4;
    end
  end

  assign req_entry = '{pc: pc, raw: NOP_WORD};

  always_comb begin
    rsp_entry     = pcq_head;
    rsp_entry.raw = imem_rsp_data;
  end

  // In-flight request PCs; every response retires one, stale or not.
  fetch_fifo #(.DEPTH(MAX_OUTSTANDING)) u_pc_queue (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (1'b0),
    .push      (req_fire),
    .push_data (req_entry),
    .pop       (imem_rsp_valid),
    .head      (pcq_head),
    .count     (outstanding)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (redirect_valid),
    .push      (fifo_push),
    .push_data (rsp_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign imem_req_addr = pc;
  assign instr_valid   = (fifo_count != '0);
  assign instr_raw     = instr_valid ? fifo_head.raw : 32'h0;
  assign instr_pc      = instr_valid ? fifo_head.pc  : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_raw;
  logic [31:0] instr_pc;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_pc;
  logic        rsp_en;
  logic [31:0] mq[$];

  fetch_unit #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2), .MAX_OUTSTANDING(2)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_raw      (instr_raw),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0013_A5C3;
  endfunction

  // In-order memory: one-cycle latency while rsp_en is set, holds responses otherwise.
  initial begin
    logic        hs;
    logic [31:0] ha;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      #4;
      hs = rstn && imem_req_valid && imem_req_ready;
      ha = imem_req_addr;
      @(posedge clk);
      #1;
      if (!rstn) begin
        mq.delete();
        imem_rsp_valid = 1'b0;
      end else begin
        if (hs) mq.push_back(ha);
        if (rsp_en && (mq.size() != 0)) begin
          ha = mq.pop_front();
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(ha);
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = 32'hDEAD_BEEF;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; rsp_en = 1'b1;
    step(); step();
    vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid got %b want 0", imem_req_valid); end
    vectors++; if (imem_req_addr !== 32'h100) begin miscompares++; $display("FAIL rst_req_addr got %h want 00000100", imem_req_addr); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_instr_valid got %b want 0", instr_valid); end
    vectors++; if (instr_raw !== 32'h0) begin miscompares++; $display("FAIL rst_instr_raw got %h want 0", instr_raw); end
    vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL rst_instr_pc got %h want 0", instr_pc); end
  endtask

  task automatic test_first_fetch();
    rstn = 1'b1;
    step();
    vectors++; if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL t1_req0_valid got %b want 1", imem_req_valid); end
    vectors++; if (imem_req_addr !== 32'h100) begin miscompares++; $display("FAIL t1_req0_addr got %h want 00000100", imem_req_addr); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL t1_valid0 got %b want 0", instr_valid); end
    step();
    vectors++; if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL t1_req1_valid got %b want 1", imem_req_valid); end
    vectors++; if (imem_req_addr !== 32'h104) begin miscompares++; $display("FAIL t1_req1_addr got %h want 00000104", imem_req_addr); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL t1_valid1 got %b want 0", instr_valid); end
    step();
    vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL t1_first_valid got %b want 1", instr_valid); end
    vectors++; if (instr_pc !== 32'h100) begin miscompares++; $display("FAIL t1_first_pc got %h want 00000100", instr_pc); end
    vectors++; if (instr_raw !== mem_word(32'h100)) begin miscompares++; $display("FAIL t1_first_raw got %h want %h", instr_raw, mem_word(32'h100)); end
    vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL t1_credit_stop got %b want 0", imem_req_valid); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL t3_req_stalled[%0d] got %b want 0", i, imem_req_valid); end
      vectors++; if (instr_pc !== 32'h100) begin miscompares++; $display("FAIL t3_head_pc[%0d] got %h want 00000100", i, instr_pc); end
      vectors++; if (instr_raw !== mem_word(32'h100)) begin miscompares++; $display("FAIL t3_head_raw[%0d] got %h want %h", i, instr_raw, mem_word(32'h100)); end
    end
  endtask

  task automatic test_streaming();
    int got = 0;
    instr_ready = 1'b1;
    exp_pc = 32'h100;
    #1;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      if (instr_valid) begin
        vectors++; if (instr_pc !== exp_pc) begin miscompares++; $display("FAIL t2_pc got %h want %h", instr_pc, exp_pc); end
        vectors++; if (instr_raw !== mem_word(exp_pc)) begin miscompares++; $display("FAIL t2_raw got %h want %h", instr_raw, mem_word(exp_pc)); end
        exp_pc += 32'd4;
        got++;
      end
      step();
    end
    vectors++; if (got != 8) begin miscompares++; $display("FAIL t2_count got %0d want 8", got); end
  endtask

  task automatic test_redirect_inflight();
    int   got = 0;
    logic found = 1'b0;
    logic stale = 1'b0;
    rsp_en = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (instr_valid) begin
        vectors++; if (instr_pc !== exp_pc) begin miscompares++; $display("FAIL t4_drain_pc got %h want %h", instr_pc, exp_pc); end
        exp_pc += 32'd4;
      end
      step();
    end
    vectors++; if (mq.size() != 2) begin miscompares++; $display("FAIL t4_inflight got %0d want 2", mq.size()); end
    vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL t4_req_blocked got %b want 0", imem_req_valid); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL t4_drained got %b want 0", instr_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    step();
    redirect_valid = 1'b0; rsp_en = 1'b1;
    #1;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL t4_after_redirect_valid got %b want 0", instr_valid); end
    vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL t4_flush_req got %b want 0", imem_req_valid); end
    for (int cyc = 0; cyc < 10 && !found; cyc++) begin
      if (imem_req_valid) begin
        found = 1'b1;
        vectors++; if (imem_req_addr !== 32'h200) begin miscompares++; $display("FAIL t4_new_addr got %h want 00000200", imem_req_addr); end
      end else begin
        if (instr_valid) stale = 1'b1;
        step();
      end
    end
    vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL t4_restart_timeout got %b want 1", found); end
    vectors++; if (stale !== 1'b0) begin miscompares++; $display("FAIL t4_stale_seen got %b want 0", stale); end
    exp_pc = 32'h200;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      if (instr_valid) begin
        vectors++; if (instr_pc !== exp_pc) begin miscompares++; $display("FAIL t4_pc got %h want %h", instr_pc, exp_pc); end
        vectors++; if (instr_raw !== mem_word(exp_pc)) begin miscompares++; $display("FAIL t4_raw got %h want %h", instr_raw, mem_word(exp_pc)); end
        exp_pc += 32'd4;
        got++;
      end
      step();
    end
    vectors++; if (got != 4) begin miscompares++; $display("FAIL t4_count got %0d want 4", got); end
  endtask

  task automatic test_redirect_collision();
    int   got = 0;
    logic found = 1'b0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      if (instr_valid && imem_rsp_valid) begin
        found = 1'b1;
        vectors++; if (instr_pc !== exp_pc) begin miscompares++; $display("FAIL t5_taken_pc got %h want %h", instr_pc, exp_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h400;
      end else begin
        if (instr_valid) begin
          vectors++; if (instr_pc !== exp_pc) begin miscompares++; $display("FAIL t5_pre_pc got %h want %h", instr_pc, exp_pc); end
          exp_pc += 32'd4;
        end
        step();
      end
    end
    vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL t5_collision_timeout got %b want 1", found); end
    step();
    redirect_valid = 1'b0;
    #1;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL t5_fifo_empty got %b want 0", instr_valid); end
    exp_pc = 32'h400;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      if (instr_valid) begin
        vectors++; if (instr_pc !== exp_pc) begin miscompares++; $display("FAIL t5_pc got %h want %h", instr_pc, exp_pc); end
        exp_pc += 32'd4;
        got++;
      end
      step();
    end
    vectors++; if (got != 4) begin miscompares++; $display("FAIL t5_count got %0d want 4", got); end
  endtask

  task automatic test_pc_wrap();
    int got = 0;
    if (instr_valid) begin
      vectors++; if (instr_pc !== exp_pc) begin miscompares++; $display("FAIL wrap_taken_pc got %h want %h", instr_pc, exp_pc); end
    end
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFB;
    step();
    redirect_valid = 1'b0;
    #1;
    exp_pc = 32'hFFFF_FFF8;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      if (instr_valid) begin
        vectors++; if (instr_pc !== exp_pc) begin miscompares++; $display("FAIL wrap_pc got %h want %h", instr_pc, exp_pc); end
        vectors++; if (instr_raw !== mem_word(exp_pc)) begin miscompares++; $display("FAIL wrap_raw got %h want %h", instr_raw, mem_word(exp_pc)); end
        exp_pc += 32'd4;
        got++;
      end
      step();
    end
    vectors++; if (got != 4) begin miscompares++; $display("FAIL wrap_count got %0d want 4", got); end
  endtask

  task automatic test_async_reset();
    int got = 0;
    step();
    #2;
    rstn = 1'b0;
    #1;
    vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL t6_req_valid got %b want 0", imem_req_valid); end
    vectors++; if (imem_req_addr !== 32'h100) begin miscompares++; $display("FAIL t6_req_addr got %h want 00000100", imem_req_addr); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL t6_instr_valid got %b want 0", instr_valid); end
    vectors++; if (instr_raw !== 32'h0) begin miscompares++; $display("FAIL t6_instr_raw got %h want 0", instr_raw); end
    vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL t6_instr_pc got %h want 0", instr_pc); end
    step(); step();
    rstn = 1'b1;
    step();
    vectors++; if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL t6_restart_valid got %b want 1", imem_req_valid); end
    vectors++; if (imem_req_addr !== 32'h100) begin miscompares++; $display("FAIL t6_restart_addr got %h want 00000100", imem_req_addr); end
    exp_pc = 32'h100;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      if (instr_valid) begin
        vectors++; if (instr_pc !== exp_pc) begin miscompares++; $display("FAIL t6_pc got %h want %h", instr_pc, exp_pc); end
        exp_pc += 32'd4;
        got++;
      end
      step();
    end
    vectors++; if (got != 4) begin miscompares++; $display("FAIL t6_count got %0d want 4", got); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_streaming();
    test_redirect_inflight();
    test_redirect_collision();
    test_pc_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
